display_mux: RTL and testbench

Time-multiplexed scan controller for the common-anode multi-digit 7-segment display on the calculator board. It holds a packed word of BCD digits plus decimal points and presents one digit per scan slot. It drives the 4-bit code into the downstream BCD-to-segment decoder and the matching active-low digit select to the anodes. Leading-zero blanking and tear-free frame-synchronous loading are handled here, so the arithmetic core only has to pulse `load` with a new result.

---
 rtl/display_mux_if.sv | 25 ++
 rtl/display_mux.sv | 102 ++++++++++
 tb/tb_display_mux.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/display_mux_if.sv
// Bundles the load/data inputs and scan outputs of the 7-segment display scanner.
// The master side is the controlling logic; the slave side is display_mux itself.
interface display_mux_if #(
  parameter int N_DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*N_DIGITS-1:0] digits_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [3:0]            bcd_out;
  logic [N_DIGITS-1:0]   dig_sel;
  logic                  dp_out;
  logic                  frame_done;
  logic                  load_ack;

  modport master (
    output enable, load, digits_in, dp_in,
    input  bcd_out, dig_sel, dp_out, frame_done, load_ack
  );

  modport slave (
    input  enable, load, digits_in, dp_in,
    output bcd_out, dig_sel, dp_out, frame_done, load_ack
  );
endinterface

// File: rtl/display_mux.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display,
// with leading-zero blanking and frame-synchronous (tear-free) loading via a shadow register.
module display_mux #(
  parameter int N_DIGITS = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK_LZ = 1
) (
  input logic         clk,
  input logic         rst,
  display_mux_if.slave bus
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*N_DIGITS-1:0] r_actDig;
  logic [N_DIGITS-1:0]   r_actDp;
  logic [4*N_DIGITS-1:0] r_shDig;
  logic [N_DIGITS-1:0]   r_shDp;
  logic                  r_pending;
  logic                  r_frameDone;
  logic                  r_loadAck;

  logic                  w_slotEnd;
  logic                  w_boundary;
  logic [N_DIGITS-1:0]   w_blank;

  assign w_slotEnd  = (r_cnt == CNT_MAX);
  assign w_boundary = w_slotEnd && (r_idx == IDX_MAX);

  // A load on the boundary bypasses the shadow so the newest data wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_actDig    <= '0;
      r_actDp     <= '0;
      r_shDig     <= '0;
      r_shDp      <= '0;
      r_pending   <= 1'b0;
      r_frameDone <= 1'b0;
      r_loadAck   <= 1'b0;
    end else begin
      r_cnt <= w_slotEnd ? '0 : r_cnt + 1'b1;
      if (w_slotEnd) begin
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end
      r_frameDone <= w_boundary;
      r_loadAck   <= 1'b0;
      if (bus.load) begin
        if (w_boundary) begin
          r_actDig  <= bus.digits_in;
          r_actDp   <= bus.dp_in;
          r_pending <= 1'b0;
          r_loadAck <= 1'b1;
        end else begin
          r_shDig   <= bus.digits_in;
          r_shDp    <= bus.dp_in;
          r_pending <= 1'b1;
        end
      end else if (w_boundary && r_pending) begin
        r_actDig  <= r_shDig;
        r_actDp   <= r_shDp;
        r_pending <= 1'b0;
        r_loadAck <= 1'b1;
      end
    end
  end

  // Walk from the most significant digit down; a digit stays blank only while
  // every digit above it (and itself) is a plain zero without a decimal point.
  always_comb begin : blankCalc
    logic lzRun;
    lzRun   = 1'b1;
    w_blank = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lzRun      = lzRun && (r_actDig[4*i +: 4] == 4'd0) && !r_actDp[i];
      w_blank[i] = (BLANK_LZ != 0) && (i > 0) && lzRun;
    end
  end

  always_comb begin
    bus.dig_sel = '1;
    bus.bcd_out = 4'd0;
    bus.dp_out  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if ((r_idx == IW'(i)) && bus.enable && !w_blank[i]) begin
        bus.dig_sel[i] = 1'b0;
        bus.bcd_out    = r_actDig[4*i +: 4];
        bus.dp_out     = r_actDp[i];
      end
    end
  end

  assign bus.frame_done = r_frameDone;
  assign bus.load_ack   = r_loadAck;

endmodule

// File: tb/tb_display_mux.sv
// Self-checking bench: two display_mux instances (blanking on/off) share one stimulus
// stream and are compared each cycle against a frame-time reference model.
module tb_display_mux;

  localparam int N  = 4;
  localparam int P  = 4;
  localparam int FR = N * P;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b1;
  logic           ld = 1'b0;
  logic [4*N-1:0] digitsIn = '0;
  logic [N-1:0]   dpIn = '0;

  int checks = 0;
  int errors = 0;
  int ackSeen = 0;

  // Reference model: time since reset plus active/shadow digit arrays
  int         t = 0;
  bit         modelValid = 1'b0;
  logic [3:0] actD [N];
  logic       actP [N];
  logic [3:0] shD  [N];
  logic       shP  [N];
  bit         pend = 1'b0;
  logic       expFd = 1'b0;
  logic       expAck = 1'b0;

  display_mux_if #(.N_DIGITS(N)) busB ();
  display_mux_if #(.N_DIGITS(N)) busN ();

  assign busB.enable = en;
  assign busB.load = ld;
  assign busB.digits_in = digitsIn;
  assign busB.dp_in = dpIn;
  assign busN.enable = en;
  assign busN.load = ld;
  assign busN.digits_in = digitsIn;
  assign busN.dp_in = dpIn;

  display_mux #(.N_DIGITS(N), .PRESCALE(P), .BLANK_LZ(1)) dutB (
    .clk(clk),
    .rst(rst),
    .bus(busB.slave)
  );

  display_mux #(.N_DIGITS(N), .PRESCALE(P), .BLANK_LZ(0)) dutN (
    .clk(clk),
    .rst(rst),
    .bus(busN.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Expected visible outputs, derived from the display rules at the current frame time
  task automatic expOut(input bit blk, output logic [N-1:0] sel, output logic [3:0] bcd,
                        output logic dp);
    int  idx;
    bit  hidden;
    idx    = (t % FR) / P;
    hidden = 1'b0;
    if (blk && idx > 0) begin
      hidden = 1'b1;
      for (int j = idx; j < N; j++) begin
        if (actD[j] != 4'd0 || actP[j]) hidden = 1'b0;
      end
    end
    sel = '1;
    bcd = 4'd0;
    dp  = 1'b0;
    if (en && !hidden) begin
      sel[idx] = 1'b0;
      bcd      = actD[idx];
      dp       = actP[idx];
    end
  endtask

  task automatic checkOutput();
    logic [N-1:0] sel;
    logic [3:0]   bcd;
    logic         dp;
    expOut(1'b1, sel, bcd, dp);
    check("blank.dig_sel", 32'(busB.dig_sel), 32'(sel));
    check("blank.bcd_out", 32'(busB.bcd_out), 32'(bcd));
    check("blank.dp_out", 32'(busB.dp_out), 32'(dp));
    check("blank.frame_done", 32'(busB.frame_done), 32'(expFd));
    check("blank.load_ack", 32'(busB.load_ack), 32'(expAck));
    expOut(1'b0, sel, bcd, dp);
    check("noblank.dig_sel", 32'(busN.dig_sel), 32'(sel));
    check("noblank.bcd_out", 32'(busN.bcd_out), 32'(bcd));
    check("noblank.dp_out", 32'(busN.dp_out), 32'(dp));
    check("noblank.load_ack", 32'(busN.load_ack), 32'(expAck));
  endtask

  task automatic modelStep();
    bit boundary;
    if (rst) begin
      t = 0;
      pend = 1'b0;
      expFd = 1'b0;
      expAck = 1'b0;
      for (int i = 0; i < N; i++) begin
        actD[i] = 4'd0; actP[i] = 1'b0; shD[i] = 4'd0; shP[i] = 1'b0;
      end
      modelValid = 1'b1;
    end else begin
      boundary = ((t % FR) == FR - 1);
      expFd  = boundary;
      expAck = 1'b0;
      if (ld) begin
        for (int i = 0; i < N; i++) begin
          if (boundary) begin
            actD[i] = digitsIn[4*i +: 4]; actP[i] = dpIn[i];
          end else begin
            shD[i] = digitsIn[4*i +: 4]; shP[i] = dpIn[i];
          end
        end
        pend   = !boundary;
        expAck = boundary;
      end else if (boundary && pend) begin
        for (int i = 0; i < N; i++) begin
          actD[i] = shD[i]; actP[i] = shP[i];
        end
        pend   = 1'b0;
        expAck = 1'b1;
      end
      t++;
    end
  endtask

  // One clock: check the settled outputs at negedge, then advance model and DUT together
  task automatic cycle();
    @(negedge clk);
    if (modelValid) checkOutput();
    ackSeen += int'(busB.load_ack);
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic applyStimulus(input logic [4*N-1:0] d, input logic [N-1:0] p);
    digitsIn = d;
    dpIn = p;
    ld = 1'b1;
    cycle();
    ld = 1'b0;
  endtask

  task automatic runToPos(input int pos);
    int guard;
    guard = 0;
    while ((t % FR) != pos && guard < 2 * FR) begin
      cycle();
      guard++;
    end
    check("runToPos.reached", 32'(t % FR), 32'(pos));
  endtask

  initial begin
    int ackBase;
    logic [4*N-1:0] rd;
    logic [N-1:0]   rp;

    rst = 1'b1;
    run(2);
    rst = 1'b0;
    check("reset.dig_sel", 32'(busB.dig_sel), 32'h0000000e);
    check("reset.bcd_out", 32'(busB.bcd_out), 32'h0);
    run(40);

    applyStimulus(16'h0042, 4'b0000);
    run(20);
    applyStimulus(16'h0005, 4'b0010);
    run(20);
    applyStimulus(16'h0000, 4'b0000);
    run(20);

    runToPos(3);
    ackBase = ackSeen;
    applyStimulus(16'h0789, 4'b0000);
    run(2);
    applyStimulus(16'h0123, 4'b0100);
    run(FR + 2);
    check("doubleLoad.ackCount", 32'(ackSeen - ackBase), 32'd1);

    runToPos(5);
    applyStimulus(16'h0456, 4'b0000);
    runToPos(FR - 1);
    ackBase = ackSeen;
    applyStimulus(16'h0901, 4'b1000);
    check("boundaryLoad.bcd_out", 32'(busB.bcd_out), 32'd1);
    run(FR + 2);
    check("boundaryLoad.ackCount", 32'(ackSeen - ackBase), 32'd1);

    runToPos(4);
    applyStimulus(16'h3333, 4'b0000);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    ackBase = ackSeen;
    run(FR + 4);
    check("resetPending.ackCount", 32'(ackSeen - ackBase), 32'd0);

    en = 1'b0;
    applyStimulus(16'h0070, 4'b0000);
    run(2 * FR);
    en = 1'b1;
    run(FR);

    for (int k = 0; k < 600; k++) begin
      rd = '0;
      for (int i = 0; i < N; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r >= 8) rd[4*i +: 4] = 4'($urandom_range(10, 15));
        else if (r >= 5) rd[4*i +: 4] = 4'($urandom_range(1, 9));
      end
      for (int i = 0; i < N; i++) rp[i] = ($urandom_range(0, 7) == 0);
      digitsIn = rd;
      dpIn = rp;
      ld = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    ld = 1'b0;
    rst = 1'b0;
    run(FR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
